// File: rtl/core_muldiv.sv
// Multi-cycle RISC-V M-extension multiply/divide unit: one operation in flight,
// result held in DONE until consumed. Multiplier is combinational or radix-2 iterative.
module core_muldiv #(
    parameter int XLEN          = 32,
    parameter bit MUL_ITERATIVE = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg_cond(input logic [XLEN-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_wide(input logic [2*XLEN-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] mul_sel(input logic [2*XLEN-1:0] p, input logic [2:0] o);
        return (o == 3'b000) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;

    logic signed [XLEN-1:0] a_s, b_s;
    logic                   is_div, a_sgn, b_sgn, sa, sb;
    logic [XLEN-1:0]        mag_a, mag_b, special_res;
    logic                   b_zero, ovf, special;
    logic [2*XLEN-1:0]      prod_comb;

    assign a_s    = a;
    assign b_s    = b;
    assign is_div = op[2];
    assign a_sgn  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign b_sgn  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign sa     = a_sgn && (a_s < 0);
    assign sb     = b_sgn && (b_s < 0);
    assign mag_a  = neg_cond(a, sa);
    assign mag_b  = neg_cond(b, sb);

    assign b_zero      = (b == '0);
    assign ovf         = is_div && !op[0] && (a == MOST_NEG) && (b == '1);
    assign special     = is_div && (b_zero || ovf);
    assign special_res = b_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    assign prod_comb   = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};

    // One iteration step: restoring divide (hi = remainder, lo = dividend/quotient)
    // or shift-add multiply (hi:lo = partial product, lo LSB = current multiplier bit).
    logic [XLEN:0]     rem_sh;
    logic              take;
    logic [XLEN-1:0]   diff;
    logic [XLEN:0]     sum;
    logic [XLEN-1:0]   step_hi, step_lo, final_res;

    always_comb begin
        rem_sh = {hi_q, lo_q[XLEN-1]};
        take   = (rem_sh >= {1'b0, opnd_q});
        diff   = rem_sh[XLEN-1:0] - opnd_q;
        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        if (op_q[2]) begin
            step_hi = take ? diff : rem_sh[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], take};
        end else begin
            step_hi = sum[XLEN:1];
            step_lo = {sum[0], lo_q[XLEN-1:1]};
        end
        if (op_q[2])
            final_res = op_q[1] ? neg_cond(step_hi, neg_rem_q) : neg_cond(step_lo, neg_q);
        else
            final_res = mul_sel(neg_wide({step_hi, step_lo}, neg_q), op_q);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        op_d      = op_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_d      = op;
                        neg_d     = sa ^ sb;
                        neg_rem_d = sa;
                        opnd_d    = is_div ? mag_b : mag_a;
                        lo_d      = is_div ? mag_a : mag_b;
                        hi_d      = '0;
                        cnt_d     = CW'(XLEN - 1);
                        if (special) begin
                            result_d = special_res;
                            state_d  = S_DONE;
                        end else if (!is_div && !MUL_ITERATIVE) begin
                            result_d = mul_sel(neg_wide(prod_comb, sa ^ sb), op);
                            state_d  = S_DONE;
                        end else begin
                            state_d = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    hi_d = step_hi;
                    lo_d = step_lo;
                    if (cnt_q == '0) begin
                        result_d = final_res;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q      <= op_d;
        neg_q     <= neg_d;
        neg_rem_q <= neg_rem_d;
        hi_q      <= hi_d;
        lo_q      <= lo_d;
        opnd_q    <= opnd_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY) || (state_q == S_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_core_muldiv.sv
// Directed and reference-model bench for core_muldiv: a 32-bit combinational-multiply
// instance and an 8-bit iterative-multiply instance share one clock and reset.
module tb_core_muldiv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        x_flush, x_in_valid, x_in_ready, x_out_valid, x_out_ready, x_busy;
    logic [2:0]  x_op;
    logic [31:0] x_a, x_b, x_result;

    logic        y_flush, y_in_valid, y_in_ready, y_out_valid, y_out_ready, y_busy;
    logic [2:0]  y_op;
    logic [7:0]  y_a, y_b, y_result;

    int n_checks = 0;
    int n_errors = 0;

    core_muldiv #(.XLEN(32), .MUL_ITERATIVE(1'b0)) u_x (
        .clk(clk), .rst(rst), .flush(x_flush), .in_valid(x_in_valid), .in_ready(x_in_ready),
        .op(x_op), .a(x_a), .b(x_b), .out_valid(x_out_valid), .out_ready(x_out_ready),
        .result(x_result), .busy(x_busy)
    );

    core_muldiv #(.XLEN(8), .MUL_ITERATIVE(1'b1)) u_y (
        .clk(clk), .rst(rst), .flush(y_flush), .in_valid(y_in_valid), .in_ready(y_in_ready),
        .op(y_op), .a(y_a), .b(y_b), .out_valid(y_out_valid), .out_ready(y_out_ready),
        .result(y_result), .busy(y_busy)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns one time unit after the accept edge, i.e. in cycle 1.
    task automatic start32(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb);
        @(negedge clk);
        x_op = o; x_a = aa; x_b = bb; x_in_valid = 1'b1;
        @(posedge clk);
        #1;
        x_in_valid = 1'b0;
    endtask

    task automatic consume32();
        @(negedge clk);
        x_out_ready = 1'b1;
        @(posedge clk);
        #1;
        x_out_ready = 1'b0;
    endtask

    task automatic start8(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb);
        @(negedge clk);
        y_op = o; y_a = aa; y_b = bb; y_in_valid = 1'b1;
        @(posedge clk);
        #1;
        y_in_valid = 1'b0;
    endtask

    task automatic consume8();
        @(negedge clk);
        y_out_ready = 1'b1;
        @(posedge clk);
        #1;
        y_out_ready = 1'b0;
    endtask

    function automatic logic [7:0] ref8(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb);
        int sa, sb, ua, ub, p;
        sa = int'($signed(aa));
        sb = int'($signed(bb));
        ua = int'(aa);
        ub = int'(bb);
        p  = 0;
        case (o)
            3'd0: begin p = ua * ub; return p[7:0]; end
            3'd1: begin p = sa * sb; return p[15:8]; end
            3'd2: begin p = sa * ub; return p[15:8]; end
            3'd3: begin p = ua * ub; return p[15:8]; end
            3'd4: begin
                if (bb == 8'h00) return 8'hFF;
                if (aa == 8'h80 && bb == 8'hFF) return 8'h80;
                p = sa / sb; return p[7:0];
            end
            3'd5: begin
                if (bb == 8'h00) return 8'hFF;
                p = ua / ub; return p[7:0];
            end
            3'd6: begin
                if (bb == 8'h00) return aa;
                if (aa == 8'h80 && bb == 8'hFF) return 8'h00;
                p = sa % sb; return p[7:0];
            end
            default: begin
                if (bb == 8'h00) return aa;
                p = ua % ub; return p[7:0];
            end
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        n_checks++; if (x_in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b want 1", x_in_ready); end
        n_checks++; if (x_out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b want 0", x_out_valid); end
        n_checks++; if (x_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", x_busy); end
        n_checks++; if (x_result !== 32'h0) begin n_errors++; $display("FAIL reset_result got %h want 0", x_result); end
        n_checks++; if (y_in_ready !== 1'b1) begin n_errors++; $display("FAIL reset8_in_ready got %b want 1", y_in_ready); end
        n_checks++; if (y_result !== 8'h0) begin n_errors++; $display("FAIL reset8_result got %h want 0", y_result); end
    endtask

    task automatic test_mul_comb();
        logic [2:0]  ops [3] = '{3'b000, 3'b011, 3'b010};
        logic [31:0] av  [3] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bv  [3] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2};
        logic [31:0] ev  [3] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF};
        for (int i = 0; i < 3; i++) begin
            start32(ops[i], av[i], bv[i]);
            n_checks++; if (x_out_valid !== 1'b1) begin n_errors++; $display("FAIL mul%0d_cycle1_valid got %b want 1", i, x_out_valid); end
            n_checks++; if (x_result !== ev[i]) begin n_errors++; $display("FAIL mul%0d_result got %h want %h", i, x_result, ev[i]); end
            consume32();
            n_checks++; if (x_in_ready !== 1'b1) begin n_errors++; $display("FAIL mul%0d_in_ready_after got %b want 1", i, x_in_ready); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [3] = '{3'b100, 3'b110, 3'b101};
        logic [31:0] av  [3] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] ev  [3] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC};
        for (int i = 0; i < 3; i++) begin
            start32(ops[i], av[i], 32'd2);
            tick(31);
            n_checks++; if (x_out_valid !== 1'b0 || x_busy !== 1'b1) begin n_errors++; $display("FAIL div%0d_cycle32 valid/busy got %b%b want 01", i, x_out_valid, x_busy); end
            tick(1);
            n_checks++; if (x_out_valid !== 1'b1) begin n_errors++; $display("FAIL div%0d_cycle33_valid got %b want 1", i, x_out_valid); end
            n_checks++; if (x_result !== ev[i]) begin n_errors++; $display("FAIL div%0d_result got %h want %h", i, x_result, ev[i]); end
            consume32();
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] av  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bv  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ev  [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            start32(ops[i], av[i], bv[i]);
            n_checks++; if (x_out_valid !== 1'b1) begin n_errors++; $display("FAIL special%0d_cycle1_valid got %b want 1", i, x_out_valid); end
            n_checks++; if (x_result !== ev[i]) begin n_errors++; $display("FAIL special%0d_result got %h want %h", i, x_result, ev[i]); end
            consume32();
        end
    endtask

    task automatic test_backpressure();
        start32(3'b000, 32'd6, 32'd7);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            n_checks++; if (x_out_valid !== 1'b1 || x_result !== 32'd42) begin n_errors++; $display("FAIL bp_hold%0d valid %b result %h want 1 0000002a", i, x_out_valid, x_result); end
            n_checks++; if (x_in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready%0d got %b want 0", i, x_in_ready); end
        end
        @(negedge clk);
        x_out_ready = 1'b1;
        #1;
        n_checks++; if (x_in_ready !== 1'b0 || x_out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_same_cycle in_ready %b out_valid %b want 0 1", x_in_ready, x_out_valid); end
        @(posedge clk);
        #1;
        x_out_ready = 1'b0;
        n_checks++; if (x_out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_release_valid got %b want 0", x_out_valid); end
        n_checks++; if (x_in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release_in_ready got %b want 1", x_in_ready); end
    endtask

    task automatic test_flush();
        start32(3'b100, 32'd100, 32'd7);
        tick(9);
        x_flush = 1'b1;
        tick(1);
        x_flush = 1'b0;
        n_checks++; if (x_in_ready !== 1'b1 || x_out_valid !== 1'b0 || x_busy !== 1'b0) begin n_errors++; $display("FAIL flush_idle rdy/vld/busy got %b%b%b want 100", x_in_ready, x_out_valid, x_busy); end
        n_checks++; if (x_result !== 32'd42) begin n_errors++; $display("FAIL flush_result_kept got %h want 0000002a", x_result); end
        start32(3'b000, 32'h12345678, 32'h10);
        n_checks++; if (x_out_valid !== 1'b1 || x_result !== 32'h23456780) begin n_errors++; $display("FAIL flush_next_mul valid %b result %h want 1 23456780", x_out_valid, x_result); end
        consume32();
        start32(3'b000, 32'd3, 32'd5);
        @(negedge clk);
        x_flush = 1'b1; x_out_ready = 1'b1;
        @(posedge clk);
        #1;
        x_flush = 1'b0; x_out_ready = 1'b0;
        n_checks++; if (x_out_valid !== 1'b0 || x_in_ready !== 1'b1) begin n_errors++; $display("FAIL flush_done valid %b in_ready %b want 0 1", x_out_valid, x_in_ready); end
        n_checks++; if (x_result !== 32'd15) begin n_errors++; $display("FAIL flush_done_result got %h want 0000000f", x_result); end
    endtask

    task automatic test_reset_mid();
        start32(3'b100, 32'd100, 32'd7);
        tick(9);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_checks++; if (x_in_ready !== 1'b1 || x_out_valid !== 1'b0 || x_busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_idle rdy/vld/busy got %b%b%b want 100", x_in_ready, x_out_valid, x_busy); end
        n_checks++; if (x_result !== 32'd0) begin n_errors++; $display("FAIL rstmid_result got %h want 0", x_result); end
        start32(3'b000, 32'd9, 32'd9);
        n_checks++; if (x_out_valid !== 1'b1 || x_result !== 32'd81) begin n_errors++; $display("FAIL rstmid_next_mul valid %b result %h want 1 00000051", x_out_valid, x_result); end
        consume32();
    endtask

    task automatic test_iter8();
        start8(3'b001, 8'h80, 8'h80);
        tick(7);
        n_checks++; if (y_out_valid !== 1'b0 || y_busy !== 1'b1) begin n_errors++; $display("FAIL imul_cycle8 valid/busy got %b%b want 01", y_out_valid, y_busy); end
        tick(1);
        n_checks++; if (y_out_valid !== 1'b1) begin n_errors++; $display("FAIL imul_cycle9_valid got %b want 1", y_out_valid); end
        n_checks++; if (y_result !== 8'h40) begin n_errors++; $display("FAIL imul_result got %h want 40", y_result); end
        consume8();
    endtask

    task automatic test_random8();
        logic [2:0] o;
        logic [7:0] aa, bb, exp_res;
        int         k, lat, exp_lat;
        for (int i = 0; i < 80; i++) begin
            o  = 3'($urandom_range(0, 7));
            aa = 8'($urandom);
            bb = 8'($urandom);
            k  = int'($urandom_range(0, 7));
            if (k == 0) bb = 8'h00;
            if (k == 1) begin aa = 8'h80; bb = 8'hFF; end
            exp_res = ref8(o, aa, bb);
            exp_lat = (o[2] && (bb == 8'h00 || (!o[0] && aa == 8'h80 && bb == 8'hFF))) ? 1 : 9;
            start8(o, aa, bb);
            lat = 1;
            while (y_out_valid !== 1'b1 && lat < 20) begin
                tick(1);
                lat++;
            end
            n_checks++; if (lat !== exp_lat) begin n_errors++; $display("FAIL rand%0d_latency op %0d a %h b %h got %0d want %0d", i, o, aa, bb, lat, exp_lat); end
            n_checks++; if (y_result !== exp_res) begin n_errors++; $display("FAIL rand%0d_result op %0d a %h b %h got %h want %h", i, o, aa, bb, y_result, exp_res); end
            consume8();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        x_flush = 1'b0; x_in_valid = 1'b0; x_out_ready = 1'b0; x_op = 3'b0; x_a = '0; x_b = '0;
        y_flush = 1'b0; y_in_valid = 1'b0; y_out_ready = 1'b0; y_op = 3'b0; y_a = '0; y_b = '0;
        test_reset();
        test_mul_comb();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_iter8();
        test_random8();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core_muldiv.md
# core_muldiv

Parametrised multi-cycle integer multiply/divide unit for the core's execute stage, covering the RISC-V M-extension operations. It sits beside the single-cycle ALU and is used for operations the ALU does not handle. It adds operand width, a selectable multiplier architecture, a valid/ready handshake, an iterative divider, and flush support. One operation is in flight at a time, and the result is held until it is consumed.

## Interface
- XLEN, 32: operand and result width; must be ≥ 2.
- MUL_ITERATIVE, 0: multiplier architecture.
  - 0: single-cycle 2·XLEN-bit product.
  - 1: radix-2 shift-add, one bit per cycle.

- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  abandons any in-flight or held operation.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  3  operation, using RISC-V funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  rs1 operand.
- b  in  XLEN  rs2 operand.
- out_valid  out  1  result is valid; high only in DONE.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  result; holds its value while in DONE.
- busy  out  1  high in BUSY or DONE.

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: iterating.
  - DONE: out_valid=1.
- Accept: an operation is accepted on an edge where in_valid & in_ready & !flush. a, b and op are captured.
- Signedness: signedness comes from op.
  - MULH and DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - Other ops: unsigned.
  - At accept, the unit stores magnitudes |a| and |b| plus a negate flag for the final result.
  - The magnitude of the most-negative value is 2^(XLEN-1), taken as an unsigned XLEN-bit quantity.
- Multiply result selection: the full 2·XLEN-bit product is formed. MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits. Sign correction is a two's-complement negate of the full 2·XLEN-bit product.
- Divide algorithm: restoring, unsigned, one quotient bit per cycle over XLEN iterations. The remainder is (XLEN+1) bits wide internally.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Special cases: these are detected at accept and go directly to DONE with the result loaded.
  - Divide by zero (b==0):
    - DIV/DIVU → all ones.
    - REM/REMU → a.
  - Signed overflow (DIV/REM, a = -2^(XLEN-1), b = -1):
    - DIV → a.
    - REM → 0.
- Transitions:
  - IDLE → DONE on accept, when the operation is a combinational multiply (MUL_ITERATIVE=0) or a special case.
  - IDLE → BUSY on accept otherwise, with the counter loaded to XLEN-1.
  - BUSY: the counter decrements every cycle. On the cycle where the counter is 0, the final iteration and sign correction are written to result, and the state goes to DONE.
  - DONE → IDLE when out_ready=1.
- Flush:
  - In any state, the next state is IDLE and no accept occurs that cycle.
  - result is not cleared.
  - rst has priority over flush.
- Reset: state IDLE, counter 0, result 0. Outputs after reset: in_ready=1, out_valid=0, busy=0.

## Timing
- Cycle 0 is the accept edge.
- Latency:
  - Combinational multiply and special cases: out_valid=1 in cycle 1.
  - Iterative multiply and divide: BUSY for cycles 1..XLEN, out_valid=1 in cycle XLEN+1.
- Latency does not depend on operand values, except for special cases.
- Throughput:
  - DONE → IDLE takes one cycle, so the next accept is at the earliest one cycle after the out_ready handshake.
  - in_ready is low while in DONE, even when out_ready=1.
- Backpressure: out_valid and result stay stable while out_ready=0, indefinitely.
- Handshake signals: in_ready, out_valid and busy are decoded from state only. There is no combinational path from in_valid or out_ready to them.
- Reset mid-operation: on the next cycle the unit is in IDLE, and no stale out_valid is produced.
- Flush and out_ready in the same cycle: handled as a flush, and the result counts as not consumed.

## Test plan
- MUL_ITERATIVE=0, XLEN=32:
  - MUL 7×(-3) → out_valid in cycle 1, result 0xFFFFFFEB.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → result 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF(-1)×2 → result 0xFFFFFFFF.
- DIV -7/2:
  - out_valid in cycle 33, result 0xFFFFFFFD.
  - REM of the same operands → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- Special cases:
  - DIVU 5/0 → out_valid in cycle 1, result 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - result stays stable and in_ready=0 throughout.
  - Raise out_ready: out_valid drops the next cycle, and in_ready=1 the cycle after the handshake.
- Flush and reset mid-operation:
  - Assert flush in cycle 10 of a DIV → IDLE in cycle 11, no out_valid.
  - A new MUL accepted in cycle 11 → completes correctly.
  - Repeat with rst in place of flush → result=0.
- MUL_ITERATIVE=1, XLEN=8:
  - MULH 0x80×0x80 → out_valid in cycle 9, result 0x40.
  - Random signed and unsigned ops across all 8 opcodes, checked against a reference model.
